// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drains a synchronous FIFO, one word at a time, onto an asynchronous serial
//   line. Frame format: start bit (0), DWIDTH data bits LSB first, and one stop bit (1).
//   This block must be the only reader of the FIFO.
//
// Parameters
//   DWIDTH       data bits per frame (equal to the FIFO data width)
//   CLKS_PER_BIT clk cycles per serial bit, minimum 2
//
// Ports
//   clk        single rising-edge clock
//   rstn       synchronous active-low reset
//   fifo_empty FIFO empty flag
//   fifo_dout  FIFO read data, valid the cycle after a fifo_rd_en pulse
//   fifo_rd_en one-cycle pop request per word
//   tx         serial output, idle high
//   busy       high whenever the transmitter is not idle
//   frame_done one-cycle pulse on the last clk of each stop bit
module fifo_uart_tx #(
  parameter int unsigned DWIDTH       = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DWIDTH) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PENULT = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(DWIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t              r_state;
  logic [BAUD_W-1:0]   r_baud;
  logic [BIT_W-1:0]    r_bit;
  logic [DWIDTH-1:0]   r_shift;
  logic                r_tx;
  logic                r_rd_en;
  logic                r_busy;
  logic                r_done;

  logic                w_baud_last;
  logic [DWIDTH-1:0]   w_shift_next;

  assign w_baud_last  = (r_baud == BAUD_LAST);
  assign w_shift_next = r_shift >> 1;

  assign tx         = r_tx;
  assign fifo_rd_en = r_rd_en;
  assign busy       = r_busy;
  assign frame_done = r_done;

  // Every output is computed one cycle ahead, on the transition into the state
  // that owns it, so each one comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (!fifo_empty) begin
            r_state <= FETCH;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        FETCH: begin
          r_state <= LOAD;
        end
        LOAD: begin
          r_shift <= fifo_dout;
          r_bit   <= '0;
          r_baud  <= '0;
          r_tx    <= 1'b0;
          r_state <= START;
        end
        START: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        DATA: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_shift <= w_shift_next;
            if (r_bit == BIT_LAST) begin
              r_bit   <= '0;
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit <= r_bit + BIT_W'(1);
              r_tx  <= w_shift_next[0];
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        STOP: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (!fifo_empty) begin
              r_state <= FETCH;
              r_rd_en <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
            // Raised one cycle early so the flop is high during the final stop cycle.
            if (r_baud == BAUD_PENULT) begin
              r_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: DWIDTH=8, CLKS_PER_BIT=4, with an 8-deep
// behavioural FIFO attached to the read port.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int FRAME_CYC = CPB * (DW + 2);

  logic          clk = 1'b0;
  logic          rstn;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DWIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // ---------------- behavioural 8-deep FIFO ----------------
  logic          f_rstn;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] mem [8];
  logic [3:0]    cnt;
  logic [2:0]    wp, rp;
  logic          fifo_full;
  logic          do_w, do_r;
  int            overflow = 0;

  assign fifo_empty = (cnt == 4'd0);
  assign fifo_full  = (cnt == 4'd8);

  always @(posedge clk) begin
    if (!f_rstn) begin
      cnt       <= 4'd0;
      wp        <= 3'd0;
      rp        <= 3'd0;
      fifo_dout <= '0;
    end else begin
      do_w = wr_en && !fifo_full;
      do_r = fifo_rd_en && !fifo_empty;
      if (wr_en && fifo_full) overflow++;
      if (do_w) begin
        mem[wp] <= wr_data;
        wp      <= wp + 3'd1;
      end
      if (do_r) begin
        fifo_dout <= mem[rp];
        rp        <= rp + 3'd1;
      end
      cnt <= cnt + 4'(do_w) - 4'(do_r);
    end
  end

  // ---------------- scoreboard and counters ----------------
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb  [$];
  logic [DW-1:0] obs [$];
  int            gaps [$];
  int            rd_pulses = 0;
  int            done_pulses = 0;

  // ---------------- line monitor (samples on falling edge) ----------------
  bit                     in_frame = 0;
  bit                     after_frame = 0;
  int                     cyc = 0;
  int                     gap_run = 0;
  logic [FRAME_CYC-1:0]   samp;

  always @(negedge clk) begin
    if (rstn !== 1'b1) begin
      in_frame    = 0;
      after_frame = 0;
    end else begin
      if (fifo_rd_en === 1'b1) begin
        rd_pulses++;
        checks++;
        if (fifo_empty !== 1'b0) begin
          errors++;
          $display("FAIL pop_when_empty got empty=%b required 0", fifo_empty);
        end
      end
      if (!in_frame) begin
        if (tx === 1'b0) begin
          in_frame = 1;
          cyc      = 0;
          samp[0]  = 1'b0;
          if (after_frame) gaps.push_back(gap_run);
        end else if (after_frame) begin
          gap_run++;
        end
      end else begin
        cyc++;
        samp[cyc] = tx;
      end
      if (frame_done === 1'b1) begin
        done_pulses++;
        checks++;
        if (!(in_frame && cyc == FRAME_CYC - 1)) begin
          errors++;
          $display("FAIL frame_done_pos got cycle %0d in_frame %0d required cycle %0d", cyc, in_frame, FRAME_CYC - 1);
        end
      end
      if (in_frame && cyc == FRAME_CYC - 1) begin
        logic [DW-1:0] d;
        logic          ok;
        ok = 1'b1;
        for (int b = 0; b < DW + 2; b++) begin
          for (int k = 0; k < CPB; k++) begin
            if (samp[b*CPB+k] !== samp[b*CPB]) ok = 1'b0;
          end
        end
        if (samp[0] !== 1'b0) ok = 1'b0;
        if (samp[(DW+1)*CPB] !== 1'b1) ok = 1'b0;
        for (int j = 0; j < DW; j++) d[j] = samp[(j+1)*CPB+1];
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL frame_format got %h required start 0, stable %0d-cycle cells, stop 1", samp, CPB);
        end
        obs.push_back(d);
        in_frame    = 0;
        after_frame = 1;
        gap_run     = 0;
      end
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_write(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    sb.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c;
    c = 0;
    while (obs.size() < n && c < budget) begin
      tick();
      c++;
    end
  endtask

  task automatic clear_counts();
    rd_pulses   = 0;
    done_pulses = 0;
    after_frame = 0;
    obs.delete();
    gaps.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn    = 1'b0;
    f_rstn  = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    tick();
    f_rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({tx, fifo_rd_en, busy, frame_done} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got tx/rd/busy/done=%b required 1000", i, {tx, fifo_rd_en, busy, frame_done});
      end
      if (i < 2) tick();
    end
    checks++;
    if (rd_pulses !== 0) begin
      errors++;
      $display("FAIL reset_pops got %0d required 0", rd_pulses);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    logic [DW-1:0] e;
    clear_counts();
    push_write(8'hA5);
    checks++;
    if ({fifo_empty, fifo_rd_en, tx} !== 3'b001) begin
      errors++;
      $display("FAIL single_w0 got empty/rd/tx=%b required 001", {fifo_empty, fifo_rd_en, tx});
    end
    tick();
    checks++;
    if ({fifo_rd_en, busy, tx} !== 3'b111) begin
      errors++;
      $display("FAIL single_fetch got rd/busy/tx=%b required 111", {fifo_rd_en, busy, tx});
    end
    tick();
    checks++;
    if ({fifo_rd_en, tx} !== 2'b01) begin
      errors++;
      $display("FAIL single_load got rd/tx=%b required 01", {fifo_rd_en, tx});
    end
    tick();
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL single_start_edge got tx=%b required 0", tx);
    end
    wait_frames(1, 200);
    checks++;
    if (obs.size() < 1 || sb.size() < 1) begin
      errors++;
      $display("FAIL single_timeout got frames %0d required 1", obs.size());
    end else begin
      e = sb.pop_front();
      if (obs[0] !== e) begin
        errors++;
        $display("FAIL single_data got %h required %h", obs[0], e);
      end
      void'(obs.pop_front());
    end
    repeat (3) tick();
    checks++;
    if (rd_pulses !== 1 || done_pulses !== 1 || busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_counts got rd %0d done %0d busy %b tx %b required 1 1 0 1", rd_pulses, done_pulses, busy, tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    int c;
    clear_counts();
    push_write(8'h00);
    push_write(8'hFF);
    push_write(8'h3C);
    c = 0;
    while (rd_pulses < 3 && c < 400) begin
      tick();
      c++;
    end
    checks++;
    if (rd_pulses < 3 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_empty_after_fetch got rd %0d empty %b required 3 1", rd_pulses, fifo_empty);
    end
    wait_frames(3, 200);
    checks++;
    if (obs.size() < 3) begin
      errors++;
      $display("FAIL b2b_timeout got frames %0d required 3", obs.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (obs.size() > 0 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs[0] !== e) begin
          errors++;
          $display("FAIL b2b_data%0d got %h required %h", i, obs[0], e);
        end
        void'(obs.pop_front());
      end
    end
    checks++;
    if (gaps.size() !== 2) begin
      errors++;
      $display("FAIL b2b_gap_count got %0d required 2", gaps.size());
    end
    foreach (gaps[i]) begin
      checks++;
      if (gaps[i] !== 2) begin
        errors++;
        $display("FAIL b2b_gap%0d got %0d required 2", i, gaps[i]);
      end
    end
    checks++;
    if (rd_pulses !== 3) begin
      errors++;
      $display("FAIL b2b_pops got %0d required 3", rd_pulses);
    end
    repeat (4) tick();
  endtask

  task automatic test_empty_fifo();
    int bad;
    clear_counts();
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      checks++;
      if ({fifo_rd_en, tx, busy} !== 3'b010) begin
        errors++;
        bad++;
        if (bad < 4) $display("FAIL empty_idle cycle %0d got rd/tx/busy=%b required 010", i, {fifo_rd_en, tx, busy});
      end
    end
    checks++;
    if (rd_pulses !== 0) begin
      errors++;
      $display("FAIL empty_pops got %0d required 0", rd_pulses);
    end
  endtask

  task automatic test_reset_mid_data();
    logic [DW-1:0] e;
    logic [DW-1:0] lost;
    int c;
    clear_counts();
    push_write(8'h5A);
    push_write(8'h81);
    c = 0;
    while (tx !== 1'b0 && c < 50) begin
      tick();
      c++;
    end
    // Start bit began at the edge just passed; bit 3 spans edges +16..+19.
    repeat (17) tick();
    lost = 8'h5A;
    checks++;
    if (tx !== lost[3] || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_bit3 got tx %b busy %b required %b 1", tx, busy, lost[3]);
    end
    rstn = 1'b0;
    tick();
    checks++;
    if ({tx, busy, fifo_rd_en, frame_done} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_reset got tx/busy/rd/done=%b required 1000", {tx, busy, fifo_rd_en, frame_done});
    end
    rstn = 1'b1;
    void'(sb.pop_front());
    wait_frames(1, 200);
    checks++;
    if (obs.size() < 1 || sb.size() < 1) begin
      errors++;
      $display("FAIL mid_timeout got frames %0d required 1", obs.size());
    end else begin
      e = sb.pop_front();
      if (obs[0] !== e) begin
        errors++;
        $display("FAIL mid_data got %h required %h", obs[0], e);
      end
      void'(obs.pop_front());
    end
    repeat (100) tick();
    checks++;
    if (obs.size() !== 0 || rd_pulses !== 2 || fifo_empty !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_resend got extra %0d rd %0d empty %b busy %b required 0 2 1 0", obs.size(), rd_pulses, fifo_empty, busy);
    end
  endtask

  task automatic test_full_drain();
    logic [DW-1:0] e;
    int c;
    int busy_drops;
    clear_counts();
    for (int i = 1; i <= 8; i++) push_write(DW'(i));
    busy_drops = 0;
    c = 0;
    while (done_pulses < 8 && c < 600) begin
      if (busy !== 1'b1) busy_drops++;
      tick();
      c++;
    end
    checks++;
    if (busy_drops !== 0) begin
      errors++;
      $display("FAIL drain_busy got %0d low cycles required 0", busy_drops);
    end
    wait_frames(8, 50);
    checks++;
    if (obs.size() !== 8) begin
      errors++;
      $display("FAIL drain_frames got %0d required 8", obs.size());
    end
    for (int i = 0; i < 8; i++) begin
      if (obs.size() > 0 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs[0] !== e) begin
          errors++;
          $display("FAIL drain_data%0d got %h required %h", i, obs[0], e);
        end
        void'(obs.pop_front());
      end
    end
    checks++;
    if (rd_pulses !== 8 || overflow !== 0) begin
      errors++;
      $display("FAIL drain_pops got rd %0d overflow %0d required 8 0", rd_pulses, overflow);
    end
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL drain_idle got busy %b tx %b required 0 1", busy, tx);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_empty_fifo();
    test_reset_mid_data();
    test_full_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
